// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: datapath width, instruction size and the
// fetch controller state encoding.
package riscv_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_LOAD  = 2'd2,
      S_FAULT = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fills the IF/ID register from a
// combinational single-port imem and arbitrates that port with the program loader.
module if_fetch_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned     IMEM_DEPTH = 1024,
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,

   output logic [XLEN-1:0] imem_addr_o,
   input  logic [XLEN-1:0] imem_instr_i,
   output logic            imem_we_o,
   output logic [XLEN-1:0] imem_wdata_o,

   input  logic            id_ready_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,

   output logic            if_valid_o,
   output logic [XLEN-1:0] if_instr_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic [XLEN-1:0] if_pc_plus4_o,

   output logic            fault_o,
   output logic [XLEN-1:0] fault_pc_o,

   input  logic            ld_req_i,
   input  logic            ld_we_i,
   input  logic [XLEN-1:0] ld_addr_i,
   input  logic [XLEN-1:0] ld_wdata_i,
   output logic            ld_gnt_o
);

   localparam logic [XLEN-1:0] PcLimit = XLEN'(IMEM_DEPTH * INSTR_BYTES);
   localparam logic [XLEN-1:0] PcStep  = XLEN'(INSTR_BYTES);

   fetch_state_t    state_q;
   logic [XLEN-1:0] pc_q;
   logic            if_valid_q;
   logic [XLEN-1:0] if_instr_q;
   logic [XLEN-1:0] if_pc_q;
   logic            fault_q;
   logic [XLEN-1:0] fault_pc_q;

   logic            pc_bad;
   logic            advance;

   // Grant tracks ld_req inside S_LOAD so release hands the port back in the same cycle.
   assign ld_gnt_o     = (state_q == S_LOAD) && ld_req_i;
   assign imem_addr_o  = ld_gnt_o ? ld_addr_i : pc_q;
   assign imem_we_o    = ld_we_i && ld_gnt_o;
   assign imem_wdata_o = ld_wdata_i;

   assign pc_bad  = (pc_q[1:0] != 2'b00) || (pc_q >= PcLimit);
   assign advance = !if_valid_q || id_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_instr_q <= '0;
         if_pc_q    <= '0;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_q <= ld_req_i ? S_LOAD : S_FETCH;
            end
            S_FETCH: begin
               if (ld_req_i) begin
                  state_q    <= S_LOAD;
                  if_valid_q <= 1'b0;
               end else if (redirect_valid_i) begin
                  if_valid_q <= 1'b0;
                  pc_q       <= redirect_pc_i;
               end else if (advance) begin
                  // Address is only checked when a capture would actually happen.
                  if (pc_bad) begin
                     state_q    <= S_FAULT;
                     if_valid_q <= 1'b0;
                     fault_q    <= 1'b1;
                     fault_pc_q <= pc_q;
                  end else begin
                     if_valid_q <= 1'b1;
                     if_instr_q <= imem_instr_i;
                     if_pc_q    <= pc_q;
                     pc_q       <= pc_q + PcStep;
                  end
               end
            end
            S_FAULT: begin
               if (ld_req_i) begin
                  state_q <= S_LOAD;
               end else if (redirect_valid_i) begin
                  state_q <= S_FETCH;
                  fault_q <= 1'b0;
                  pc_q    <= redirect_pc_i;
               end
            end
            S_LOAD: begin
               if (!ld_req_i) begin
                  state_q <= S_IDLE;
                  pc_q    <= RESET_PC;
                  fault_q <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign if_valid_o    = if_valid_q;
   assign if_instr_o    = if_instr_q;
   assign if_pc_o       = if_pc_q;
   assign if_pc_plus4_o = if_pc_q + PcStep;
   assign fault_o       = fault_q;
   assign fault_pc_o    = fault_pc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a behavioural 1024-word imem model.
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        imem_we;
   logic [31:0] imem_wdata;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        fault;
   logic [31:0] fault_pc;
   logic        ld_req;
   logic        ld_we;
   logic [31:0] ld_addr;
   logic [31:0] ld_wdata;
   logic        ld_gnt;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [1024];

   always #5 clk = ~clk;

   // Memory is reloaded with word i = 0x1000_0000 + i whenever reset is held.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      end else if (imem_we) begin
         mem[imem_addr[11:2]] <= imem_wdata;
      end
   end

   assign imem_instr = (imem_addr < 32'h1000) ? mem[imem_addr[11:2]] : 32'h0;

   if_fetch_ctrl #(
      .IMEM_DEPTH(1024),
      .RESET_PC  (32'h0000_0000)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .imem_addr_o     (imem_addr),
      .imem_instr_i    (imem_instr),
      .imem_we_o       (imem_we),
      .imem_wdata_o    (imem_wdata),
      .id_ready_i      (id_ready),
      .redirect_valid_i(redirect_valid),
      .redirect_pc_i   (redirect_pc),
      .if_valid_o      (if_valid),
      .if_instr_o      (if_instr),
      .if_pc_o         (if_pc),
      .if_pc_plus4_o   (if_pc_plus4),
      .fault_o         (fault),
      .fault_pc_o      (fault_pc),
      .ld_req_i        (ld_req),
      .ld_we_i         (ld_we),
      .ld_addr_i       (ld_addr),
      .ld_wdata_i      (ld_wdata),
      .ld_gnt_o        (ld_gnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] instr);
      chk({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
      chk({tag, "_pc"}, if_pc, pc);
      chk({tag, "_instr"}, if_instr, instr);
      chk({tag, "_pc4"}, if_pc_plus4, pc + 32'd4);
   endtask

   initial begin
      rst = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
      cyc(); cyc();
      chk("rst_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_instr", if_instr, 32'd0);
      chk("rst_pc", if_pc, 32'd0);
      chk("rst_fault", {31'b0, fault}, 32'd0);
      chk("rst_gnt", {31'b0, ld_gnt}, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);

      // Release: idle bubble, then sequential fetch 0,4,8.
      rst = 1'b0;
      cyc();
      chk("bubble_valid", {31'b0, if_valid}, 32'd0);
      cyc(); chk_if("seq0", 32'h0, 32'h1000_0000);
      cyc(); chk_if("seq4", 32'h4, 32'h1000_0001);
      cyc(); chk_if("seq8", 32'h8, 32'h1000_0002);

      // Three-cycle stall holds IF/ID and pc.
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk_if("stall", 32'h8, 32'h1000_0002);
         chk("stall_pc", imem_addr, 32'hC);
      end
      id_ready = 1'b1;
      cyc(); chk_if("resume", 32'hC, 32'h1000_0003);
      cyc(); chk_if("seq10", 32'h10, 32'h1000_0004);

      // Redirect while stalled.
      id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
      cyc();
      chk("redir_bubble", {31'b0, if_valid}, 32'd0);
      chk("redir_pc", imem_addr, 32'h40);
      redirect_valid = 1'b0;
      cyc(); chk_if("redir_tgt", 32'h40, 32'h1000_0010);
      id_ready = 1'b1;

      // Misaligned redirect target faults.
      redirect_valid = 1'b1; redirect_pc = 32'h42;
      cyc();
      redirect_valid = 1'b0;
      cyc();
      chk("mis_fault", {31'b0, fault}, 32'd1);
      chk("mis_fault_pc", fault_pc, 32'h42);
      chk("mis_valid", {31'b0, if_valid}, 32'd0);

      // Recover to last word, then run off the end.
      redirect_valid = 1'b1; redirect_pc = 32'hFFC;
      cyc();
      chk("recover_fault", {31'b0, fault}, 32'd0);
      redirect_valid = 1'b0;
      cyc(); chk_if("last", 32'hFFC, 32'h1000_03FF);
      cyc();
      chk("end_fault", {31'b0, fault}, 32'd1);
      chk("end_fault_pc", fault_pc, 32'h1000);
      chk("end_valid", {31'b0, if_valid}, 32'd0);
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      cyc();
      chk("clr_fault", {31'b0, fault}, 32'd0);
      redirect_valid = 1'b0;
      cyc(); chk_if("clr_tgt", 32'h0, 32'h1000_0000);

      // Loader request beats a same-cycle redirect.
      ld_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
      cyc();
      chk("ld_gnt", {31'b0, ld_gnt}, 32'd1);
      chk("ld_valid", {31'b0, if_valid}, 32'd0);
      redirect_valid = 1'b0;
      ld_we = 1'b1; ld_addr = 32'h8; ld_wdata = 32'hDEAD_BEEF;
      #1;
      chk("ld_addr", imem_addr, 32'h8);
      chk("ld_we", {31'b0, imem_we}, 32'd1);
      chk("ld_wdata", imem_wdata, 32'hDEAD_BEEF);
      cyc();
      ld_we = 1'b0; ld_req = 1'b0;
      #1;
      chk("ld_rel_gnt", {31'b0, ld_gnt}, 32'd0);
      chk("ld_rel_we", {31'b0, imem_we}, 32'd0);
      cyc();
      chk("ld_idle_valid", {31'b0, if_valid}, 32'd0);
      chk("ld_idle_pc", imem_addr, 32'h0);
      cyc();
      cyc(); chk_if("ld_f0", 32'h0, 32'h1000_0000);
      cyc(); chk_if("ld_f4", 32'h4, 32'h1000_0001);
      cyc(); chk_if("ld_f8", 32'h8, 32'hDEAD_BEEF);

      // Leave a fault_pc behind, then reset in the middle of a load.
      redirect_valid = 1'b1; redirect_pc = 32'h2000;
      cyc();
      redirect_valid = 1'b0;
      cyc();
      chk("far_fault_pc", fault_pc, 32'h2000);
      ld_req = 1'b1;
      cyc();
      ld_we = 1'b1; ld_addr = 32'h4; ld_wdata = 32'h1234_5678;
      #1;
      chk("load2_gnt", {31'b0, ld_gnt}, 32'd1);
      rst = 1'b1;
      cyc();
      chk("rl_gnt", {31'b0, ld_gnt}, 32'd0);
      chk("rl_we", {31'b0, imem_we}, 32'd0);
      chk("rl_valid", {31'b0, if_valid}, 32'd0);
      chk("rl_instr", if_instr, 32'd0);
      chk("rl_pc", if_pc, 32'd0);
      chk("rl_fault", {31'b0, fault}, 32'd0);
      chk("rl_fault_pc", fault_pc, 32'd0);
      chk("rl_addr", imem_addr, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
